// File: rtl/mxv_payload_rx.sv
// Payload-capture stage of the MxV UART receive path: stores LENGTH bytes into the buffer,
// then reports DONE/ERROR and releases the length-field controller. Optional XOR checksum: CHECKSUM_EN.
module mxv_payload_rx #(
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RXINT,
  input  logic [7:0]        RXDATA,
  input  logic              LOCKEDFLAG,
  input  logic [15:0]       LENGTH,
  output logic              CLEARFLAG,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [7:0]        WDATA,
  output logic              UNLOCKME,
  output logic              DONEFLAG,
  output logic              ERRFLAG
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CHKLEN   = 4'd1,
    WAITBYTE = 4'd2,
    STORE    = 4'd3,
    GAP      = 4'd4,
    WAITSUM  = 4'd5,
    CLRSUM   = 4'd6,
    DONE     = 4'd7,
    ERROR    = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
`ifdef CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
`ifdef CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifdef CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
`ifdef CHECKSUM_EN
    csum_d    = csum_q;
`endif
    CLEARFLAG = 1'b0;
    WE        = 1'b0;
    WADDR     = '0;
    WDATA     = '0;
    UNLOCKME  = 1'b0;
    DONEFLAG  = 1'b0;
    ERRFLAG   = 1'b0;

    case (state_q)
      IDLE: begin
        if (LOCKEDFLAG) begin
          len_d   = LENGTH;
          cnt_d   = '0;
`ifdef CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = CHKLEN;
        end
      end
      CHKLEN: begin
        // 17-bit compare so MAX_LEN = 65536 still works.
        if (len_q == 16'd0 || {1'b0, len_q} > 17'(MAX_LEN)) state_d = ERROR;
        else                                                 state_d = WAITBYTE;
      end
      WAITBYTE: begin
        if (!LOCKEDFLAG) state_d = ERROR;
        else if (RXINT)  state_d = STORE;
      end
      STORE: begin
        WE        = 1'b1;
        CLEARFLAG = 1'b1;
        WADDR     = cnt_q[ADDR_W-1:0];
        WDATA     = RXDATA;
        cnt_d     = cnt_q + 16'd1;
`ifdef CHECKSUM_EN
        csum_d    = csum_q ^ RXDATA;
`endif
        state_d   = GAP;
      end
      GAP: begin
        // RXINT may still be high here until the clear lands; it is deliberately not looked at.
        if (cnt_q == len_q) begin
`ifdef CHECKSUM_EN
          state_d = WAITSUM;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = WAITBYTE;
        end
      end
`ifdef CHECKSUM_EN
      WAITSUM: begin
        if (!LOCKEDFLAG) state_d = ERROR;
        else if (RXINT)  state_d = CLRSUM;
      end
      CLRSUM: begin
        CLEARFLAG = 1'b1;
        state_d   = (RXDATA == csum_q) ? DONE : ERROR;
      end
`endif
      DONE: begin
        DONEFLAG = 1'b1;
        UNLOCKME = 1'b1;
        state_d  = IDLE;
      end
      ERROR: begin
        ERRFLAG  = 1'b1;
        UNLOCKME = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
